// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the baud divider calculation used by both the RX and TX halves.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest: round(clk / (baud*16)).
  function automatic int baud_div(input int clk_freq, input int baud);
    int den;
    den = baud * OVERSAMPLE;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Receiver-side bus: serial line in, received byte and status strobes out.
//
// Handshake: Rx_Done is a valid-only strobe. Data is valid in exactly the
// cycle Rx_Done is high and there is no ready; the receiver cannot be
// back-pressured, so the consumer must take the byte in that cycle (Data
// does hold afterwards until the next good byte). Frame_Err is a one-cycle
// strobe that never coincides with Rx_Done. Busy is a level.
interface uart_byte_rx_if;
  logic       uart_rx;
  logic [7:0] Data;
  logic       Rx_Done;
  logic       Frame_Err;
  logic       Busy;

  // Line source / byte consumer side.
  modport master (
    output uart_rx,
    input  Data,
    input  Rx_Done,
    input  Frame_Err,
    input  Busy
  );

  // Receiver side.
  modport slave (
    input  uart_rx,
    output Data,
    output Rx_Done,
    output Frame_Err,
    output Busy
  );
endinterface

// File: rtl/uart_byte_rx_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last
// count. A synchronous clear restarts the phase so it can be aligned to an
// external event such as a detected start edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // Next count: clear wins, otherwise wrap on tick or increment.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled with a 2-of-3 majority vote
// at tick indices 7, 8 and 9 of every bit. Good bytes appear on Data with a
// one-cycle Rx_Done; a low stop bit gives a one-cycle Frame_Err and the
// receiver then waits for a full bit period of idle line before re-arming.
module uart_byte_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  uart_byte_rx_if.slave        bus,
  output uart_pkg::rx_state_t  dbg_state
);

  import uart_pkg::*;

  localparam int         DIV       = baud_div(CLK_FREQ, BAUD);
  localparam logic [3:0] TIDX_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMPLE_A  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMPLE_B  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] SAMPLE_C  = 4'(OVERSAMPLE / 2 + 1);

  rx_state_t  state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [1:0] prime_q, prime_d;
  logic [3:0] tidx_q, tidx_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sa_q, sa_d;
  logic       sb_q, sb_d;
  logic [7:0] data_q, data_d;
  logic       rx_done_q, rx_done_d;
  logic       frame_err_q, frame_err_d;

  logic       tick;
  logic       tick_clear;
  logic       line;
  logic       fall;
  logic       vote;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (Clk),
    .rst   (Reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // sync_q[1] is the synchronized line, sync_q[2] its one-clock-older copy.
  // prime_q masks the edge detector until the pipe has flushed its reset
  // ones, so a line that is already low at reset release does not look
  // like a start edge.
  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1] & (prime_q == 2'd3);
  assign vote = (sa_q & sb_q) | (sa_q & line) | (sb_q & line);

  // Synchronizer shift and post-reset priming counter.
  always_comb begin
    sync_d  = {sync_q[1:0], bus.uart_rx};
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
  end

  // Receive FSM: bit timing, sampling, voting, shifting and strobes.
  always_comb begin
    state_d     = state_q;
    tidx_d      = tidx_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    data_d      = data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    tick_clear  = 1'b0;

    if (tick && tidx_q == SAMPLE_A) sa_d = line;
    if (tick && tidx_q == SAMPLE_B) sb_d = line;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tidx_d     = 4'd0;
          tick_clear = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          tidx_d = tidx_q + 4'd1;
          if (tidx_q == SAMPLE_C && vote) begin
            state_d = IDLE;
          end else if (tidx_q == TIDX_LAST) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tidx_d = tidx_q + 4'd1;
          if (tidx_q == SAMPLE_C) shreg_d[bitcnt_q] = vote;
          if (tidx_q == TIDX_LAST) begin
            if (bitcnt_q == 3'd7) state_d = STOP;
            else                  bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tidx_d = tidx_q + 4'd1;
          if (tidx_q == SAMPLE_C) begin
            if (vote) begin
              data_d    = shreg_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
              tidx_d      = 4'd0;
            end
          end
        end
      end
      BREAK: begin
        // tidx counts consecutive high ticks; any low sample restarts it.
        if (tick) begin
          if (!line) begin
            tidx_d = 4'd0;
          end else if (tidx_q == TIDX_LAST) begin
            tidx_d  = 4'd0;
            state_d = IDLE;
          end else begin
            tidx_d = tidx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      sync_q      <= 3'b111;
      prime_q     <= 2'd0;
      tidx_q      <= 4'd0;
      bitcnt_q    <= 3'd0;
      shreg_q     <= 8'h00;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      data_q      <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prime_q     <= prime_d;
      tidx_q      <= tidx_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      data_q      <= data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.Data      = data_q;
  assign bus.Rx_Done   = rx_done_q;
  assign bus.Frame_Err = frame_err_q;
  assign bus.Busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
